uart_rx: RTL and testbench

- 8N1 UART receiver; the receive-side counterpart of the project's uart_tx (same CLK_FREQ/BAUD_RATE parameterisation).
- Sits between the asynchronous `rx` pad and on-chip consumers.
- Recovers bytes by mid-bit sampling and presents each byte with a one-cycle valid strobe.
- Flags framing errors, rejects start-bit glitches, and supports back-to-back frames.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_sync.sv | 16 +
 rtl/uart_rx.sv | 86 ++++++++
 tb/tb_uart_rx.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame constants, receiver state encoding and bit-timing helper
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam logic STOP_LEVEL = 1'b1;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction
endpackage

// File: rtl/uart_sync.sv
// uart_sync: multi-flop synchronizer for an asynchronous level, resetting to 1 (idle line)
module uart_sync #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [DEPTH-1:0] ff;
  // shift the raw level through DEPTH flops before anything looks at it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ff <= '1;
    else ff <= {ff[DEPTH-2:0], d};
  assign q = ff[DEPTH-1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling, glitch rejection and framing-error flag
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n, data_n;
  logic valid_n, ferr_n, rx_s;
  uart_sync #(.DEPTH(2)) u_sync (.clk(clk), .rst_n(rst_n), .d(rx), .q(rx_s));
  assign rx_busy = state != IDLE;
  // register all FSM state, datapath and output strobes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      rx_data <= data_n;
      rx_valid <= valid_n;
      frame_err <= ferr_n;
    end
  // next-state: start-bit qualification at half bit, then whole-bit steps to mid data/stop
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    idx_n = idx;
    sh_n = sh;
    data_n = rx_data;
    valid_n = 1'b0;
    ferr_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        state_n = rx_s ? IDLE : START;
      end
      START: if (cnt == HALF) begin
        cnt_n = '0;
        idx_n = '0;
        state_n = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt == LAST) begin
        cnt_n = '0;
        sh_n = {rx_s, sh[7:1]};
        idx_n = idx + 1'b1;
        state_n = idx == LAST_BIT ? STOP : DATA;
      end
      STOP: if (cnt == LAST) begin
        cnt_n = '0;
        valid_n = rx_s == STOP_LEVEL;
        ferr_n = rx_s != STOP_LEVEL;
        data_n = rx_s == STOP_LEVEL ? sh : rx_data;
        state_n = rx_s == STOP_LEVEL ? IDLE : BREAK;
      end
      BREAK: begin
        cnt_n = '0;
        state_n = rx_s ? IDLE : BREAK;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx against an expected-byte model
module tb_uart_rx;
  localparam int CLK_FREQ = 50000000;
  localparam int BAUD = 115200;
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int LAT = 2 + CPB / 2 + 9 * CPB;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
  logic [7:0] rx_data;
  logic rx_valid, rx_busy, frame_err;
  int cyc = 0, n_cmp = 0, n_bad = 0, ferr_cnt = 0, both_hi = 0;
  logic [7:0] got_q[$], exp_q[$];
  int vt_q[$];
  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_busy(rx_busy), .frame_err(frame_err)
  );
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // observe strobes away from the active edge
  always @(negedge clk) if (rst_n) begin
    if (rx_valid) begin
      got_q.push_back(rx_data);
      vt_q.push_back(cyc);
    end
    if (frame_err) ferr_cnt++;
    if (rx_valid && frame_err) both_hi++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // drive one frame; bit edges at round(k*p) clocks from the start edge
  task automatic frame(input logic [7:0] b, input real p, input logic stop, input int nstop);
    logic [8:0] bits;
    int t0;
    bits = {b, 1'b0};
    t0 = cyc;
    for (int i = 0; i < 9; i++) begin
      rx = bits[i];
      while (cyc - t0 < int'((i + 1) * p)) @(posedge clk);
    end
    rx = stop;
    while (cyc - t0 < int'((9 + nstop) * p)) @(posedge clk);
  endtask
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
  endtask
  task automatic expect_frames(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_byte"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
    vt_q.delete();
  endtask
  initial begin
    int f0, t_start;
    logic [7:0] b, last;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {rx_data, rx_valid, rx_busy, frame_err}, 32'h0);
    rst_n = 1'b1;
    idle(20);
    // loopback A5 with latency
    f0 = ferr_cnt;
    t_start = cyc;
    frame(8'hA5, real'(CPB), 1'b1, 1);
    exp_q.push_back(8'hA5);
    check("loop_lat", (vt_q.size() > 0 && vt_q[0] - t_start >= LAT - 2 && vt_q[0] - t_start <= LAT + 2), 1);
    expect_frames("loop");
    idle(5);
    check("loop_busy", rx_busy, 1'b0);
    check("loop_ferr", ferr_cnt - f0, 0);
    // random bytes with random idle gaps
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      frame(b, real'(CPB), 1'b1, 1);
      exp_q.push_back(b);
      idle($urandom_range(0, 50));
    end
    expect_frames("rand");
    // back-to-back frames
    frame(8'hA5, real'(CPB), 1'b1, 1);
    frame(8'h3C, real'(CPB), 1'b1, 1);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    check("b2b_gap", (vt_q.size() == 2 && vt_q[1] - vt_q[0] >= 10 * CPB - 2 && vt_q[1] - vt_q[0] <= 10 * CPB + 2), 1);
    expect_frames("b2b");
    idle(30);
    // start-bit glitch
    f0 = ferr_cnt;
    rx = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("glitch_busy", rx_busy, 1'b1);
    repeat (50) @(posedge clk);
    idle(CPB / 2 + 20);
    check("glitch_idle", rx_busy, 1'b0);
    expect_frames("glitch");
    check("glitch_ferr", ferr_cnt - f0, 0);
    // framing error: stop held low for three bit times
    last = 8'h3C;
    f0 = ferr_cnt;
    frame(8'h55, real'(CPB), 1'b0, 3);
    #1;
    check("ferr_busy_held", rx_busy, 1'b1);
    check("ferr_count", ferr_cnt - f0, 1);
    check("ferr_data", rx_data, last);
    expect_frames("ferr");
    idle(5);
    check("ferr_release", rx_busy, 1'b0);
    // reset during bit 4 of C3
    fork
      frame(8'hC3, real'(CPB), 1'b1, 1);
      begin
        repeat (5 * CPB + 150) @(posedge clk);
        #2;
        check("rst_was_busy", rx_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_outputs", {rx_data, rx_valid, rx_busy, frame_err}, 32'h0);
      end
    join
    idle(10);
    rst_n = 1'b1;
    idle(10);
    expect_frames("rst_mid");
    frame(8'h3C, real'(CPB), 1'b1, 1);
    exp_q.push_back(8'h3C);
    expect_frames("rst_after");
    idle(10);
    // baud skew +/-2%
    f0 = ferr_cnt;
    frame(8'h96, CPB / 1.02, 1'b1, 1);
    idle(20);
    frame(8'h96, CPB * 1.02, 1'b1, 1);
    idle(20);
    exp_q.push_back(8'h96);
    exp_q.push_back(8'h96);
    for (int k = 0; k < 2; k++) begin
      b = 8'($urandom);
      frame(b, (k == 0) ? CPB / 1.02 : CPB * 1.02, 1'b1, 1);
      exp_q.push_back(b);
      idle(20);
    end
    expect_frames("skew");
    check("skew_ferr", ferr_cnt - f0, 0);
    check("valid_and_ferr", both_hi, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
